game_display_frontend: RTL and testbench



---
 rtl/game_display_frontend.sv | 217 +++++++++++++++++++++
 tb/tb_game_display_frontend.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_display_frontend.sv
// Game display front end: reset-button conditioning (debounce + one-pulse) and a
// 640x480@60 VGA renderer for 5 balls and 4 paddles, driven from the 100 MHz clock.
// Video timing is parameterised so the raster can be shrunk; defaults give 640x480.
module game_display_frontend #(
  parameter int unsigned DB_LEN = 4,
  parameter int unsigned BALL_R = 4,
  parameter int unsigned PAD_HW = 4,
  parameter int unsigned PAD_HH = 32,
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn,
  output logic               btn_pulse,
  input  logic signed [10:0] ball1_posx,
  input  logic signed [10:0] ball1_posy,
  input  logic signed [10:0] ball2_posx,
  input  logic signed [10:0] ball2_posy,
  input  logic signed [10:0] ball3_posx,
  input  logic signed [10:0] ball3_posy,
  input  logic signed [10:0] ball4_posx,
  input  logic signed [10:0] ball4_posy,
  input  logic signed [10:0] ball5_posx,
  input  logic signed [10:0] ball5_posy,
  input  logic signed [10:0] paddle10_posx,
  input  logic signed [10:0] paddle10_posy,
  input  logic signed [10:0] paddle11_posx,
  input  logic signed [10:0] paddle11_posy,
  input  logic signed [10:0] paddle20_posx,
  input  logic signed [10:0] paddle20_posy,
  input  logic signed [10:0] paddle21_posx,
  input  logic signed [10:0] paddle21_posy,
  output logic [3:0]         vgaRed,
  output logic [3:0]         vgaGreen,
  output logic [3:0]         vgaBlue,
  output logic               hsync,
  output logic               vsync
);

  localparam int unsigned HTotal = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast     = 10'(HTotal - 1);
  localparam logic [9:0] VLast     = 10'(VTotal - 1);
  localparam logic [9:0] HVisEnd   = 10'(H_VIS);
  localparam logic [9:0] VVisEnd   = 10'(V_VIS);
  localparam logic [9:0] HSyncBeg  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HSyncEnd  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VSyncBeg  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VSyncEnd  = 10'(V_VIS + V_FP + V_SYNC - 1);

  localparam logic signed [11:0] BallR = 12'(BALL_R);
  localparam logic signed [11:0] PadW  = 12'(PAD_HW);
  localparam logic signed [11:0] PadH  = 12'(PAD_HH);

  // Objects 0..4 are balls, 5/6 paddles of player 1, 7/8 paddles of player 2.
  localparam int NumObj = 9;

  logic [DB_LEN-1:0] db_sh_q;
  logic              db_q;
  logic              db_dly_q;
  logic              btn_pulse_q;

  logic [1:0]        div_q;
  logic              pix_en;
  logic [9:0]        h_q;
  logic [9:0]        v_q;

  logic signed [10:0] pos_x [NumObj];
  logic signed [10:0] pos_y [NumObj];
  logic signed [10:0] sh_x_q [NumObj];
  logic signed [10:0] sh_y_q [NumObj];

  logic [11:0]        rgb_q;
  logic               hsync_q;
  logic               vsync_q;

  logic signed [11:0] hpos;
  logic signed [11:0] vpos;
  logic               ball_hit;
  logic               p1_hit;
  logic               p2_hit;
  logic               visible;
  logic [11:0]        rgb_d;

  assign pos_x[0] = ball1_posx;    assign pos_y[0] = ball1_posy;
  assign pos_x[1] = ball2_posx;    assign pos_y[1] = ball2_posy;
  assign pos_x[2] = ball3_posx;    assign pos_y[2] = ball3_posy;
  assign pos_x[3] = ball4_posx;    assign pos_y[3] = ball4_posy;
  assign pos_x[4] = ball5_posx;    assign pos_y[4] = ball5_posy;
  assign pos_x[5] = paddle10_posx; assign pos_y[5] = paddle10_posy;
  assign pos_x[6] = paddle11_posx; assign pos_y[6] = paddle11_posy;
  assign pos_x[7] = paddle20_posx; assign pos_y[7] = paddle20_posy;
  assign pos_x[8] = paddle21_posx; assign pos_y[8] = paddle21_posy;

  function automatic logic signed [11:0] sext(input logic signed [10:0] a);
    return {a[10], a};
  endfunction

  // Square/rectangle hit: c-r <= p <= c+r-1 on both axes, so the side is 2*r.
  function automatic logic box_hit(input logic signed [11:0] hp, input logic signed [11:0] vp,
                                   input logic signed [11:0] cx, input logic signed [11:0] cy,
                                   input logic signed [11:0] rx, input logic signed [11:0] ry);
    return (hp >= cx - rx) && (hp <= cx + rx - 12'sd1) &&
           (vp >= cy - ry) && (vp <= cy + ry - 12'sd1);
  endfunction

  // Button conditioning: shift-register debounce, then a registered rising-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_sh_q     <= '0;
      db_q        <= 1'b0;
      db_dly_q    <= 1'b0;
      btn_pulse_q <= 1'b0;
    end else begin
      db_sh_q     <= {db_sh_q[DB_LEN-2:0], btn};
      db_q        <= &db_sh_q;
      db_dly_q    <= db_q;
      btn_pulse_q <= db_q & ~db_dly_q;
    end
  end

  assign btn_pulse = btn_pulse_q;

  // Pixel-clock divider and raster counters; both counters move only on pix_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 2'd0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_q + 2'd1;
      if (pix_en) begin
        if (h_q == HLast) begin
          h_q <= '0;
          v_q <= (v_q == VLast) ? '0 : v_q + 10'd1;
        end else begin
          h_q <= h_q + 10'd1;
        end
      end
    end
  end

  assign pix_en = (div_q == 2'd3);

  // Capture object positions once per frame so a frame never mixes old and new positions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumObj; i++) begin
        sh_x_q[i] <= '0;
        sh_y_q[i] <= '0;
      end
    end else if (pix_en && (h_q == HLast) && (v_q == VLast)) begin
      for (int i = 0; i < NumObj; i++) begin
        sh_x_q[i] <= pos_x[i];
        sh_y_q[i] <= pos_y[i];
      end
    end
  end

  assign hpos    = {2'b00, h_q};
  assign vpos    = {2'b00, v_q};
  assign visible = (h_q < HVisEnd) && (v_q < VVisEnd);

  // Hit tests against the shadow positions and colour priority: ball > player 1 > player 2.
  always_comb begin
    ball_hit = 1'b0;
    p1_hit   = 1'b0;
    p2_hit   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ball_hit = ball_hit | box_hit(hpos, vpos, sext(sh_x_q[i]), sext(sh_y_q[i]), BallR, BallR);
    end
    for (int i = 5; i < 7; i++) begin
      p1_hit = p1_hit | box_hit(hpos, vpos, sext(sh_x_q[i]), sext(sh_y_q[i]), PadW, PadH);
    end
    for (int i = 7; i < 9; i++) begin
      p2_hit = p2_hit | box_hit(hpos, vpos, sext(sh_x_q[i]), sext(sh_y_q[i]), PadW, PadH);
    end
    rgb_d = 12'h000;
    if (visible) begin
      if (ball_hit) begin
        rgb_d = 12'hFFF;
      end else if (p1_hit) begin
        rgb_d = 12'hF00;
      end else if (p2_hit) begin
        rgb_d = 12'h00F;
      end
    end
  end

  // Colour and syncs registered together from the same (h,v) to keep them aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q   <= 12'h000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (pix_en) begin
      rgb_q   <= rgb_d;
      hsync_q <= ~((h_q >= HSyncBeg) && (h_q <= HSyncEnd));
      vsync_q <= ~((v_q >= VSyncBeg) && (v_q <= VSyncEnd));
    end
  end

  assign vgaRed   = rgb_q[11:8];
  assign vgaGreen = rgb_q[7:4];
  assign vgaBlue  = rgb_q[3:0];
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;

endmodule

// File: tb/tb_game_display_frontend.sv
// Bench for game_display_frontend: one full-size instance (real 640x480 line timing)
// and one shrunken-raster instance so several whole frames fit in a short run.
// Every clock both instances are compared against a pixel-index reference model.
module tb_game_display_frontend;

  localparam int DbLen = 4;

  // Per-instance geometry: index 0 = full-size DUT, 1 = small-raster DUT.
  localparam int HV [2] = '{640, 32};
  localparam int HF [2] = '{16, 2};
  localparam int HS [2] = '{96, 4};
  localparam int HB [2] = '{48, 2};
  localparam int VV [2] = '{480, 24};
  localparam int VF [2] = '{10, 1};
  localparam int VS [2] = '{2, 2};
  localparam int VB [2] = '{33, 2};
  localparam int BR [2] = '{4, 2};
  localparam int PW [2] = '{4, 2};
  localparam int PH [2] = '{32, 5};

  localparam int SmallFrameClk = (32 + 2 + 4 + 2) * (24 + 1 + 2 + 2) * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btn = 1'b0;
  logic signed [10:0] px [9];
  logic signed [10:0] py [9];

  logic [3:0] r_f, g_f, b_f, r_s, g_s, b_s;
  logic hs_f, vs_f, hs_s, vs_s, pl_f, pl_s;
  logic [13:0] obs_f, obs_s;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  game_display_frontend u_dut_full (
    .clk(clk), .rst_n(rst_n), .btn(btn), .btn_pulse(pl_f),
    .ball1_posx(px[0]), .ball1_posy(py[0]), .ball2_posx(px[1]), .ball2_posy(py[1]),
    .ball3_posx(px[2]), .ball3_posy(py[2]), .ball4_posx(px[3]), .ball4_posy(py[3]),
    .ball5_posx(px[4]), .ball5_posy(py[4]),
    .paddle10_posx(px[5]), .paddle10_posy(py[5]), .paddle11_posx(px[6]), .paddle11_posy(py[6]),
    .paddle20_posx(px[7]), .paddle20_posy(py[7]), .paddle21_posx(px[8]), .paddle21_posy(py[8]),
    .vgaRed(r_f), .vgaGreen(g_f), .vgaBlue(b_f), .hsync(hs_f), .vsync(vs_f)
  );

  game_display_frontend #(
    .DB_LEN(4), .BALL_R(2), .PAD_HW(2), .PAD_HH(5),
    .H_VIS(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_VIS(24), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .btn_pulse(pl_s),
    .ball1_posx(px[0]), .ball1_posy(py[0]), .ball2_posx(px[1]), .ball2_posy(py[1]),
    .ball3_posx(px[2]), .ball3_posy(py[2]), .ball4_posx(px[3]), .ball4_posy(py[3]),
    .ball5_posx(px[4]), .ball5_posy(py[4]),
    .paddle10_posx(px[5]), .paddle10_posy(py[5]), .paddle11_posx(px[6]), .paddle11_posy(py[6]),
    .paddle20_posx(px[7]), .paddle20_posy(py[7]), .paddle21_posx(px[8]), .paddle21_posy(py[8]),
    .vgaRed(r_s), .vgaGreen(g_s), .vgaBlue(b_s), .hsync(hs_s), .vsync(vs_s)
  );

  assign obs_f = {r_f, g_f, b_f, hs_f, vs_f};
  assign obs_s = {r_s, g_s, b_s, hs_s, vs_s};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- video reference model ----------------
  int shx [2][9];
  int shy [2][9];
  int n_edge [2];
  int pidx;
  logic [13:0] exp_px [2];

  function automatic bit in_rect(int h, int v, int cx, int cy, int rx, int ry);
    return (h >= cx - rx) && (h < cx + rx) && (v >= cy - ry) && (v < cy + ry);
  endfunction

  // Expected {rgb, hsync, vsync} for pixel number p counted from reset.
  function automatic logic [13:0] exp_pix(input int i, input int p);
    int ht, vt, h, v;
    bit hs_n, vs_n, ball, pad1, pad2;
    logic [11:0] rgb;
    ht = HV[i] + HF[i] + HS[i] + HB[i];
    vt = VV[i] + VF[i] + VS[i] + VB[i];
    h = p % ht;
    v = (p / ht) % vt;
    hs_n = !((h >= HV[i] + HF[i]) && (h < HV[i] + HF[i] + HS[i]));
    vs_n = !((v >= VV[i] + VF[i]) && (v < VV[i] + VF[i] + VS[i]));
    ball = 1'b0;
    pad1 = 1'b0;
    pad2 = 1'b0;
    for (int k = 0; k < 5; k++) ball |= in_rect(h, v, shx[i][k], shy[i][k], BR[i], BR[i]);
    for (int k = 5; k < 7; k++) pad1 |= in_rect(h, v, shx[i][k], shy[i][k], PW[i], PH[i]);
    for (int k = 7; k < 9; k++) pad2 |= in_rect(h, v, shx[i][k], shy[i][k], PW[i], PH[i]);
    rgb = 12'h000;
    if (h < HV[i] && v < VV[i]) begin
      if (ball) rgb = 12'hFFF;
      else if (pad1) rgb = 12'hF00;
      else if (pad2) rgb = 12'h00F;
    end
    return {rgb, hs_n, vs_n};
  endfunction

  // One pixel every 4th clock after reset; positions seen at the last pixel of a
  // frame become the ones drawn in the following frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        n_edge[i] = 0;
        exp_px[i] = 14'h0003;
        for (int k = 0; k < 9; k++) begin
          shx[i][k] = 0;
          shy[i][k] = 0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_edge[i]++;
        if (n_edge[i] % 4 == 0) begin
          pidx = n_edge[i] / 4 - 1;
          exp_px[i] = exp_pix(i, pidx);
          if ((pidx + 1) % ((HV[i] + HF[i] + HS[i] + HB[i]) * (VV[i] + VF[i] + VS[i] + VB[i]))
              == 0) begin
            for (int k = 0; k < 9; k++) begin
              shx[i][k] = int'(px[k]);
              shy[i][k] = int'(py[k]);
            end
          end
        end
      end
    end
  end

  // ---------------- button reference model ----------------
  bit s_hist [$];
  bit exp_pulse;
  int pulse_cnt = 0;
  int last_pulse_edge = 0;

  // Debounced level after edge m: the DbLen samples taken at edges m-DbLen..m-1 all high.
  function automatic bit db_at(int m);
    for (int k = m - DbLen; k <= m - 1; k++) begin
      if (k < 1) return 1'b0;
      if (!s_hist[k-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_hist.delete();
      exp_pulse = 1'b0;
    end else begin
      s_hist.push_back(btn);
      exp_pulse = db_at(s_hist.size() - 1) && !db_at(s_hist.size() - 2);
    end
  end

  // Compare everything mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pix_full", 32'(obs_f), 32'(exp_px[0]));
      check("pix_small", 32'(obs_s), 32'(exp_px[1]));
      check("pulse_full", 32'(pl_f), 32'(exp_pulse));
      check("pulse_small", 32'(pl_s), 32'(exp_pulse));
      if (pl_s) begin
        pulse_cnt++;
        last_pulse_edge = s_hist.size();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_btn(input bit b);
    btn = b;
    @(posedge clk);
    #2;
  endtask

  task automatic all_off();
    for (int k = 0; k < 9; k++) begin
      px[k] = -11'sd20;
      py[k] = -11'sd20;
    end
  endtask

  task automatic set_obj(input int k, input int x, input int y);
    px[k] = 11'(x);
    py[k] = 11'(y);
  endtask

  task automatic randomize_objs();
    for (int k = 0; k < 9; k++) begin
      set_obj(k, int'($urandom_range(0, 46)) - 6, int'($urandom_range(0, 36)) - 6);
    end
  endtask

  int stable_edge;

  initial begin
    for (int k = 0; k < 9; k++) begin
      px[k] = '0;
      py[k] = '0;
    end
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    btn = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_rgb", 32'({r_s, g_s, b_s}), 32'h0);
    check("rst_hsync", 32'(hs_f), 32'd1);
    check("rst_vsync", 32'(vs_f), 32'd1);
    check("rst_pulse", 32'(pl_f), 32'd0);
    btn = 1'b0;
    rst_n = 1'b1;

    // Bouncy press then hold: exactly one pulse, DB_LEN+1 clocks after the last bounce.
    repeat (3) drive_btn(1'b0);
    drive_btn(1'b1);
    drive_btn(1'b0);
    stable_edge = s_hist.size() + 1;
    repeat (20) drive_btn(1'b1);
    check("press1_count", 32'(pulse_cnt), 32'd1);
    check("press1_latency", 32'(last_pulse_edge - stable_edge), 32'(DbLen + 1));
    repeat (8) drive_btn(1'b0);
    repeat (10) drive_btn(1'b1);
    check("press2_count", 32'(pulse_cnt), 32'd2);
    repeat (200) drive_btn($urandom_range(0, 3) != 0);
    btn = 1'b0;

    // Each scenario is shown for one whole frame after the next frame boundary.
    all_off();
    set_obj(0, 10, 6);
    repeat (SmallFrameClk) @(posedge clk);
    #2;
    all_off();
    set_obj(5, 4, 12);
    set_obj(7, 28, 12);
    repeat (SmallFrameClk) @(posedge clk);
    #2;
    all_off();
    set_obj(0, 4, 12);
    set_obj(5, 4, 12);
    repeat (SmallFrameClk) @(posedge clk);
    #2;
    repeat (3) begin
      repeat ($urandom_range(100, SmallFrameClk - 100)) @(posedge clk);
      #2;
      randomize_objs();
      repeat (SmallFrameClk) @(posedge clk);
      #2;
    end

    // Reset in the middle of a frame: outputs return to idle at once.
    repeat ($urandom_range(1000, 3000)) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rgb", 32'({r_s, g_s, b_s}), 32'h0);
    check("midrst_syncs", 32'({hs_s, vs_s, hs_f, vs_f}), 32'hF);
    check("midrst_pulse", 32'(pl_s), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    randomize_objs();
    repeat (SmallFrameClk) @(posedge clk);
    #2;
    randomize_objs();
    repeat (SmallFrameClk) @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
